// File: rtl/r2sdf_stage4_pkg.sv
// Shared complex-sample types and component helpers for the complex-arithmetic blocks.
// A packed sample is {re, im}, each component two's complement.
package r2sdf_stage4_pkg;

  localparam int CPLX_W = 12;
  localparam int CPLX_D = 4;

  typedef logic signed [CPLX_W-1:0] comp_t;
  typedef logic signed [CPLX_W:0]   comp_ext_t;
  typedef logic [2*CPLX_W-1:0]      cplx_t;

  function automatic comp_t re_of(cplx_t x);
    return comp_t'(x[2*CPLX_W-1:CPLX_W]);
  endfunction

  function automatic comp_t im_of(cplx_t x);
    return comp_t'(x[CPLX_W-1:0]);
  endfunction

  function automatic cplx_t cplx_pack(comp_t re, comp_t im);
    return {re, im};
  endfunction

  function automatic comp_ext_t sext(comp_t v);
    return comp_ext_t'({v[CPLX_W-1], v});
  endfunction

  // Floor-halving of a W+1-bit sum; the result always fits back into W bits.
  function automatic comp_t halve(comp_ext_t v);
    return comp_t'(v[CPLX_W:1]);
  endfunction

endpackage

// File: rtl/cplx_delay_line.sv
// D-deep shift register of packed complex samples; dout is the oldest entry.
module cplx_delay_line
  import r2sdf_stage4_pkg::*;
#(
  parameter int W = CPLX_W,
  parameter int D = CPLX_D
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [2*W-1:0] din,
  output logic [2*W-1:0] dout
);

  logic [2*W-1:0] mem [D];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < D; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[D-1];

endmodule

// File: rtl/r2sdf_stage4.sv
// Radix-2 SDF butterfly stage: fill phase stores samples, butterfly phase emits
// halved sums and recirculates halved differences through the delay line.
module r2sdf_stage4
  import r2sdf_stage4_pkg::*;
#(
  parameter int W = CPLX_W,
  parameter int D = CPLX_D
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  input  logic [2*W-1:0] in,
  output logic           out_valid,
  output logic [2*W-1:0] out
);

  localparam int CW = $clog2(2*D);

  logic [CW-1:0]  cnt;
  logic           primed;
  logic           bfly_p0;
  logic [2*W-1:0] dl_out, dl_in, sum_p0, diff_p0;
  logic [2*W-1:0] out_p1;
  logic           vld_p1;

  function automatic cplx_t bfly_sum(cplx_t a, cplx_t b);
    return cplx_pack(halve(sext(re_of(a)) + sext(re_of(b))),
                     halve(sext(im_of(a)) + sext(im_of(b))));
  endfunction

  function automatic cplx_t bfly_diff(cplx_t a, cplx_t b);
    return cplx_pack(halve(sext(re_of(a)) - sext(re_of(b))),
                     halve(sext(im_of(a)) - sext(im_of(b))));
  endfunction

  // Stage p0: phase decode and butterfly on the oldest stored sample.
  assign bfly_p0 = (cnt >= CW'(D));
  assign sum_p0  = bfly_sum(dl_out, in);
  assign diff_p0 = bfly_diff(dl_out, in);
  assign dl_in   = bfly_p0 ? diff_p0 : in;

  cplx_delay_line #(.W(W), .D(D)) dl (
    .clk  (clk),
    .rstn (rstn),
    .en   (in_valid),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Stage p1: registered output; during fill the previous frame's differences drain out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      primed <= 1'b0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid & (bfly_p0 | primed);
      if (in_valid) begin
        cnt    <= (cnt == CW'(2*D-1)) ? '0 : cnt + CW'(1);
        out_p1 <= bfly_p0 ? sum_p0 : dl_out;
        if (cnt == CW'(D-1)) primed <= 1'b1;
      end
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_r2sdf_stage4.sv
// Scoreboard bench for r2sdf_stage4: an integer frame model predicts each output.
module tb_r2sdf_stage4;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [23:0] din;
  logic        out_valid;
  logic [23:0] dout;

  r2sdf_stage4 dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int fb_re [8];
  int fb_im [8];
  int pd_re [4];
  int pd_im [4];
  int m_cnt;
  bit m_primed;
  bit exp_vld;
  logic [23:0] q [$];
  logic [23:0] last_out;

  function automatic int s12(logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [23:0] pk(int re, int im);
    logic [11:0] r, i;
    r = re[11:0];
    i = im[11:0];
    return {r, i};
  endfunction

  task automatic chk(string tag, logic [23:0] obs, logic [23:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_primed = 0;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      pd_re[i] = 0;
      pd_im[i] = 0;
    end
  endtask

  task automatic step(bit v, logic [23:0] x);
    int r, im, k;
    logic [23:0] e;
    in_valid = v;
    din = x;
    exp_vld = 0;
    if (v) begin
      r  = s12(x[23:12]);
      im = s12(x[11:0]);
      if (m_cnt < 4) begin
        if (m_primed) begin
          q.push_back(pk(pd_re[m_cnt], pd_im[m_cnt]));
          exp_vld = 1;
        end
        fb_re[m_cnt] = r;
        fb_im[m_cnt] = im;
      end else begin
        k = m_cnt - 4;
        q.push_back(pk((fb_re[k] + r) >>> 1, (fb_im[k] + im) >>> 1));
        pd_re[k] = (fb_re[k] - r) >>> 1;
        pd_im[k] = (fb_im[k] - im) >>> 1;
        m_primed = 1;
        exp_vld = 1;
      end
      m_cnt = (m_cnt + 1) % 8;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {23'd0, out_valid}, {23'd0, exp_vld});
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("sb_nonempty", 24'd0, 24'd1);
      end else begin
        e = q.pop_front();
        chk("out", dout, e);
      end
    end else begin
      chk("out_hold", dout, last_out);
    end
    last_out = dout;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    din = '0;
    #1;
    chk("rst_out", dout, 24'd0);
    chk("rst_valid", {23'd0, out_valid}, 24'd0);
    model_reset();
    last_out = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    din = '0;
    last_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_out", dout, 24'd0);
    chk("por_valid", {23'd0, out_valid}, 24'd0);
    rstn = 1'b1;

    // Basic frame: ramp then zeros, plus one more half-frame to drain diffs.
    for (int i = 0; i < 8; i++) step(1'b1, pk(2 * (i + 1), 0));
    for (int i = 0; i < 12; i++) step(1'b1, 24'd0);

    // Stall inside the butterfly phase, then stall right at the frame wrap.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, pk(i * 100 - 300, 50 - i * 30));
    repeat (3) step(1'b0, 24'hABCDEF);
    for (int i = 6; i < 8; i++) step(1'b1, pk(i * 100 - 300, 50 - i * 30));
    repeat (2) step(1'b0, 24'h0);
    for (int i = 0; i < 8; i++) step(1'b1, pk(-7 * i, 13 * i - 40));

    // Reset mid-frame at x5 of a primed stream.
    for (int i = 0; i < 5; i++) step(1'b1, pk(i + 1, -i - 1));
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, pk(10 * i + 5, 3 - i));

    // Extremes: sum of max/max, sum of min/min, diff of max/min.
    do_reset();
    step(1'b1, pk(12'h7FF, 12'h800));
    step(1'b1, pk(12'h800, 12'h7FF));
    step(1'b1, pk(12'h7FF, 12'h7FF));
    step(1'b1, pk(0, 0));
    step(1'b1, pk(12'h7FF, 12'h800));
    step(1'b1, pk(12'h800, 12'h800));
    step(1'b1, pk(12'h800, 12'h800));
    step(1'b1, pk(0, 0));
    repeat (4) step(1'b1, 24'd0);

    // Rounding: floor of odd halves, both signs.
    do_reset();
    step(1'b1, pk(3, -3));
    for (int i = 1; i < 8; i++) step(1'b1, 24'd0);
    repeat (4) step(1'b1, 24'd0);

    // Continuous random stream, then random with stalls.
    do_reset();
    for (int i = 0; i < 1024; i++) step(1'b1, 24'($urandom));
    for (int i = 0; i < 200; i++) step($urandom_range(0, 4) != 0, 24'($urandom));
    repeat (8) step(1'b1, 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r2sdf_stage4.md
# r2sdf_stage4

Radix-2 single-delay-feedback (SDF) butterfly stage for the complex-sample datapath. It consumes a stream of packed 24-bit complex samples (real in bits [23:12], imaginary in bits [11:0], two's complement) through a 4-deep feedback delay line. It emits the scaled butterfly sums and differences of sample pairs spaced D apart. It is the reading/consuming end of the 4-stage complex delay line. Twiddle multiplication is done downstream and is not part of this block.

## Interface
- `W`, 12, bits per real/imag component
- `D`, 4, butterfly span and delay-line depth (power of two)
- `clk`  input  1  rising-edge clock
- `rstn`  input  1  asynchronous active-low reset
- `in_valid`  input  1  `in` carries a sample this cycle
- `in`  input  2W  packed complex sample {re, im}
- `out_valid`  output  1  `out` carries a result this cycle
- `out`  output  2W  packed complex result {re, im}

## Operation
- Frame = 2D accepted samples x0..x(2D-1).
- Phase counter `cnt`, 0..2D-1, counts accepted samples. It advances only when `in_valid`=1 and wraps 2D-1 -> 0.
- Delay line `dl`, D entries of 2W bits. It shifts only on accepted samples. `dl_out` is the oldest entry.
- Fill phase (`cnt` < D):
  - `dl` takes `in`.
  - `out` takes `dl_out`, which is the previous frame's difference.
- Butterfly phase (`cnt` >= D):
  - sum = (`dl_out` + `in`) >>> 1, per component.
  - diff = (`dl_out` - `in`) >>> 1, per component.
  - `out` takes sum; `dl` takes diff.
- Arithmetic:
  - Each component is sign-extended to W+1 bits before add/sub.
  - Arithmetic shift right by 1 (floor), keeping the low W bits. No saturation is needed, because the result always fits.
- Output order per frame: sums s0..s(D-1) during the butterfly phase, then differences d0..d(D-1) during the next frame's fill phase. dk = (xk - x(k+D))/2.
- `primed` flag:
  - Cleared by reset; set on the first transition into the butterfly phase.
  - During the fill phase, `out_valid` = `in_valid` & `primed`. The first D samples after reset produce no output.
  - During the butterfly phase, `out_valid` = `in_valid`.
- Trailing differences of the last frame are emitted only when D further samples are accepted. Flush by feeding zeros.

## Timing
- Reset (asynchronous, immediate): `cnt`=0, `dl` all 0, `primed`=0, `out`=0, `out_valid`=0.
- Latency: `out`/`out_valid` are registered, one cycle after the accepting edge.
- `in_valid`=0: `cnt`, `dl` and `primed` hold. `out_valid`=0 next cycle; `out` holds its last value.
- Back-to-back input gives one output per cycle with no bubbles once primed.
- Reset mid-frame discards all partial state. The next accepted sample is x0 of a new unprimed stream.
- `cnt` wrap and a stall in the same cycle: hold takes priority, so there is no wrap without an accepted sample.

## Structure
- Shared include/package: `W`, `D`, component pack/unpack helpers (re = [2W-1:W], im = [W-1:0]), sign-extend and halve helpers. These are reused by other complex-arithmetic blocks.
- One sub-module, `cplx_delay_line`:
  - D-deep, 2W-wide shift register with shift enable and async active-low reset to 0.
  - Instantiated once as `dl`.
- Top level holds `cnt`, `primed`, the butterfly add/sub and the output mux/register.

## Test plan
- **Basic frame.** After reset, 16 back-to-back samples: x0..x7 with re = 2,4,..,16 and im = 0, then 8 zeros.
  - Expect no output for the first 4 samples.
  - Then sums re = 6,8,10,12, im = 0.
  - Then diffs re = 0xFFC (×4), im = 0.
  - Then the second frame's sums (zeros).
- **Extremes.**
  - re = 0x7FF paired with 0x7FF gives sum 0x7FF, diff 0x000.
  - re = 0x800 paired with 0x800 gives sum 0x800.
  - re = 0x7FF paired with 0x800 gives diff 0x7FF.
- **Rounding.** x0 = {3, -3}, x4 = {0, 0} gives s0 = {1, 0xFFE} and d0 = {1, 0xFFE} (floor behaviour).
- **Stall.** Drop `in_valid` for 3 cycles inside the butterfly phase.
  - `out_valid`=0 for exactly those 3 cycles.
  - The output sequence is identical to the no-stall run.
- **Reset mid-frame.** Assert `rstn`=0 at x5.
  - `out`=0 and `out_valid`=0 immediately.
  - After release, the next 4 samples produce no output and results restart from a fresh frame.
- **Continuous random.** 1024 random samples are compared against a reference model of the sum/diff sequence. Expect 0 mismatches.
